fsqrt_arbiter: RTL and testbench
================================

Name: fsqrt_arbiter

Overview:
Shares one combinational fsqrt unit among NREQ requesters, such as integer-pipeline issue ports and a vector/loader port. It arbitrates round-robin and registers the operand and result through a LATENCY-deep pipeline. Each result and its exception flag return to the originating requester through a one-entry response buffer with valid/ready backpressure. It sits between the FPU issue logic and the fsqrt datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
LATENCY, 2, register stages from operand capture to response-buffer write (>=1); fsqrt evaluated on stage-1 output

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has an operand
req_x  in  NREQ*32  operand of requester i, bits [32i+31:32i], IEEE single
req_ready  out  NREQ  accept strobe; handshake = req_valid[i] & req_ready[i]
resp_valid  out  NREQ  result buffer i holds a result
resp_y  out  NREQ*32  sqrt result for requester i
resp_exception  out  NREQ  fsqrt exception flag for requester i
resp_ready  in  NREQ  requester i consumes result

Behaviour:
- Reset (async, rstn=0): busy, resp_valid, all pipeline valid bits and rr_ptr go to 0; resp_y and resp_exception go to 0. In-flight operations are discarded; nothing is emitted after reset release.
- busy[i]: set on requester i's accept; cleared on its resp handshake (resp_valid[i] & resp_ready[i]). At most one outstanding op per requester.
- Eligible[i] = req_valid[i] & ~busy[i]. Grant is combinational, round-robin: the first eligible index starting at rr_ptr, wrapping mod NREQ. At most one grant per cycle.
- req_ready[i] = grant[i]. It depends on req_valid (same-cycle grant), never on resp_ready. A requester whose result is pending keeps req_ready=0.
- On an accept by winner w: rr_ptr <= (w+1) mod NREQ. With no accept, rr_ptr holds.
- Pipeline stage 1 captures {valid=1, tag=w, x=req_x[w]}. Stages 2..LATENCY carry {valid, tag, y, exception}, where y/exception = fsqrt(stage-1 x).
  - For LATENCY=1, fsqrt output writes the buffer directly from stage 1.
- Pipeline never stalls. The buffer for the tag is guaranteed free because busy blocks reissue.
- Final stage valid writes resp_y[tag] and resp_exception[tag] and sets resp_valid[tag].
- Latency: accept in cycle c, resp_valid[i] high from cycle c+1+LATENCY. Held with stable data until the handshake; cleared the following cycle.
- Response handshake and a new req_valid in the same cycle: the request is not granted that cycle (busy still set); earliest regrant is the next cycle.
- Simultaneous buffer write to requester i and resp handshake on i cannot occur (single outstanding op).
- Throughput: 1 op/cycle aggregate; per requester, 1 op per (LATENCY+2) cycles when resp_ready=1 at all times.
- Exception semantics come from fsqrt: sign bit 1 (including -0) or NaN input gives exception=1. Result accuracy is fsqrt's (relative error < 2^-20). The arbiter must not alter y bits.
- Ordering: results for different requesters may be visible simultaneously. Per-requester order is trivially preserved.

Decomposition:
- Package fsqrt_arb_pkg holds:
  - typedef float32_t (logic [31:0]);
  - TAG_W = $clog2(NREQ) (min 1);
  - typedef struct pipe_t {valid, tag, y, exception}.
- Sub-module rr_arbiter (NREQ; inputs eligible, rr_ptr; outputs one-hot grant, winner index).
- A single fsqrt instance inside fsqrt_arbiter.

Test Plan:
- Single request, LATENCY=2: req 0 x=0x40800000 (4.0) accepted cycle 5 -> resp_valid[0] high cycle 8, resp_y=0x40000000, exception=0; resp_ready=1 clears it cycle 9.
- All four requesters valid cycle 0: x0=0x3F800000, x1=0x41100000, x2=0x41800000, x3=0x40000000 -> grants 0,1,2,3 in cycles 0-3. Results 0x3F800000, 0x40400000, 0x40800000, 0x3FB504F3(±1 ulp) appear in consecutive cycles 3-6.
- Backpressure: req 1 resp_ready=0 for 10 cycles with req_valid[1] held -> req_ready[1]=0 throughout and resp_y stable. Others are granted normally; after the handshake, req 1 is regranted the next cycle.
- Exceptions: x=0xBF800000 (-1.0) -> exception=1; x=0x80000000 (-0) -> exception=1; x=0x7FC00000 (NaN) -> exception=1.
- Fairness: reqs 0 and 2 continuously valid with resp_ready=1 -> grants alternate 0,2,0,2; neither starves.
- Reset mid-flight: rstn low 1 cycle while 3 ops in pipeline -> all resp_valid=0, no stale result after release, first new request granted to lowest eligible index (rr_ptr=0).

Source files
------------

// File: rtl/fsqrt_arbiter_pkg.sv
// Shared types for the fsqrt arbiter: IEEE single word, pipeline entry
// and tag-width helper.
package fsqrt_arb_pkg;
  typedef logic [31:0] float32_t;

  // Widest tag for up to 8 requesters; narrower configs zero-extend.
  localparam int MAX_TAG_W = 3;
  localparam float32_t QNAN = 32'h7FC0_0000;

  function automatic int tag_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    float32_t             y;
    logic                 exception;
  } pipe_t;
endpackage

// File: rtl/fsqrt_arbiter_if.sv
// Requester-side bus of the fsqrt arbiter.
//   req_valid/req_x/req_ready   : operand handshake per requester
//   resp_valid/resp_y/resp_exception/resp_ready : result handshake
// master = requesters, slave = arbiter.
interface fsqrt_arbiter_if #(parameter int NREQ = 4);
  import fsqrt_arb_pkg::*;
  logic     [NREQ-1:0] req_valid;
  float32_t [NREQ-1:0] req_x;
  logic     [NREQ-1:0] req_ready;
  logic     [NREQ-1:0] resp_valid;
  float32_t [NREQ-1:0] resp_y;
  logic     [NREQ-1:0] resp_exception;
  logic     [NREQ-1:0] resp_ready;

  modport master (output req_valid, req_x, resp_ready,
                  input  req_ready, resp_valid, resp_y, resp_exception);
  modport slave  (input  req_valid, req_x, resp_ready,
                  output req_ready, resp_valid, resp_y, resp_exception);
endinterface

// File: rtl/fsqrt.sv
// Combinational single-precision square root.
//   x         : operand
//   y         : sqrt(x), mantissa truncated
//   exception : negative (incl. -0) or NaN operand
// Denormal inputs flush to +0; +inf passes through.
module fsqrt
  import fsqrt_arb_pkg::*;
(
  input  float32_t x,
  output float32_t y,
  output logic     exception
);
  logic [47:0] rad;
  logic [27:0] rem, trial;
  logic [23:0] root;
  logic [7:0]  res_exp;

  always_comb begin
    // Odd unbiased exponent (even biased) folds a factor 2 into the radicand.
    rad   = x[23] ? {1'b0, 1'b1, x[22:0], 23'b0} : {1'b1, x[22:0], 24'b0};
    rem   = '0;
    root  = '0;
    trial = '0;
    for (int i = 23; i >= 0; i--) begin
      rem   = {rem[25:0], rad[2*i+1 -: 2]};
      trial = {2'b00, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[22:0], 1'b1};
      end else begin
        root = {root[22:0], 1'b0};
      end
    end
    // floor((E + 127) / 2) without a dropped LSB
    res_exp   = {1'b0, x[30:24]} + 8'd63 + {7'b0, x[23]};
    exception = 1'b0;
    y         = '0;
    if (x[30:23] == 8'hFF && x[22:0] != '0) begin
      exception = 1'b1;
      y         = QNAN;
    end else if (x[31]) begin
      exception = 1'b1;
      y         = QNAN;
    end else if (x[30:23] == 8'hFF) begin
      y = 32'h7F80_0000;
    end else if (x[30:23] == 8'h00) begin
      y = '0;
    end else if (root[23]) begin
      // root MSB is the hidden bit; always set for a normal input
      y = {1'b0, res_exp, root[22:0]};
    end
  end
endmodule

// File: rtl/fsqrt_arbiter_rr_arbiter.sv
// Round-robin pick: first eligible index at or after rr_ptr, wrapping.
//   eligible : request mask
//   rr_ptr   : highest-priority index this cycle
//   grant    : one-hot winner (zero if none)
//   winner   : binary winner index
module rr_arbiter
  import fsqrt_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int TAG_W = tag_w(NREQ)
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [TAG_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [TAG_W-1:0] winner
);
  int   idx;
  logic found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = TAG_W'(idx);
      end
    end
  end
endmodule

// File: rtl/fsqrt_arbiter.sv
// Shares one fsqrt among NREQ requesters. Round-robin grant, LATENCY-deep
// non-stalling pipeline, one result buffer per requester.
//   clk, rstn : clock, async active-low reset
//   bus       : fsqrt_arbiter_if.slave (request/response handshakes)
module fsqrt_arbiter
  import fsqrt_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rstn,
  fsqrt_arbiter_if.slave  bus
);
  localparam int TAG_W = tag_w(NREQ);

  logic     [NREQ-1:0]  busy, eligible, grant, resp_hs;
  logic     [NREQ-1:0]  resp_valid, resp_exception;
  float32_t [NREQ-1:0]  resp_y;
  logic     [TAG_W-1:0] rr_ptr, winner;
  logic                 accept;

  logic                 s1_valid;
  logic [MAX_TAG_W-1:0] s1_tag;
  float32_t             s1_x, fs_y;
  logic                 fs_exc;
  pipe_t                s1_res, fin;

  // busy blocks reissue until the result is consumed, so a buffer is
  // always free when its tag reaches the end of the pipe.
  assign eligible = bus.req_valid & ~busy;
  assign accept   = |grant;
  assign resp_hs  = resp_valid & bus.resp_ready;

  rr_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) u_rr (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr   <= '0;
      busy     <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_x     <= '0;
    end else begin
      if (accept) rr_ptr <= (winner == TAG_W'(NREQ-1)) ? '0 : winner + 1'b1;
      busy     <= (busy | grant) & ~resp_hs;
      s1_valid <= accept;
      s1_tag   <= MAX_TAG_W'(winner);
      s1_x     <= bus.req_x[winner];
    end
  end

  fsqrt u_fsqrt (.x(s1_x), .y(fs_y), .exception(fs_exc));

  assign s1_res = '{valid: s1_valid, tag: s1_tag, y: fs_y, exception: fs_exc};

  if (LATENCY == 1) begin : g_lat1
    assign fin = s1_res;
  end else begin : g_pipe
    pipe_t stg [2:LATENCY];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 2; k <= LATENCY; k++) stg[k] <= '0;
      end else begin
        stg[2] <= s1_res;
        for (int k = 3; k <= LATENCY; k++) stg[k] <= stg[k-1];
      end
    end
    assign fin = stg[LATENCY];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid     <= '0;
      resp_y         <= '0;
      resp_exception <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (fin.valid && fin.tag == MAX_TAG_W'(i)) begin
          resp_valid[i]     <= 1'b1;
          resp_y[i]         <= fin.y;
          resp_exception[i] <= fin.exception;
        end else if (resp_hs[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready      = grant;
  assign bus.resp_valid     = resp_valid;
  assign bus.resp_y         = resp_y;
  assign bus.resp_exception = resp_exception;
endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Directed bench for fsqrt_arbiter (NREQ=4, LATENCY=2). Inputs are driven
// 1ns after the rising edge and outputs sampled 1ns later.
module tb_fsqrt_arbiter;
  import fsqrt_arb_pkg::*;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fsqrt_arbiter_if #(.NREQ(NREQ)) bus();

  fsqrt_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle_inputs();
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.resp_ready = '1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #1;
    n_chk++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0000", bus.resp_valid); end
    n_chk++; if (bus.resp_y !== '0) begin n_fail++; $display("FAIL reset_resp_y got %h want 0", bus.resp_y); end
    n_chk++; if (bus.resp_exception !== 4'b0) begin n_fail++; $display("FAIL reset_exc got %b want 0000", bus.resp_exception); end
    n_chk++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    tick(); tick();
    bus.req_valid[0] = 1'b1;
    bus.req_x[0]     = 32'h4080_0000;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", bus.req_ready); end
    tick(); bus.req_valid[0] = 1'b0; #1;
    n_chk++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("FAIL single_c1 got %b want 0000", bus.resp_valid); end
    tick(); #1;
    n_chk++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("FAIL single_c2 got %b want 0000", bus.resp_valid); end
    tick(); #1;
    n_chk++; if (bus.resp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_c3_valid got %b want 0001", bus.resp_valid); end
    n_chk++; if (bus.resp_y[0] !== 32'h4000_0000) begin n_fail++; $display("FAIL single_y got %h want 40000000", bus.resp_y[0]); end
    n_chk++; if (bus.resp_exception[0] !== 1'b0) begin n_fail++; $display("FAIL single_exc got %b want 0", bus.resp_exception[0]); end
    tick(); #1;
    n_chk++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("FAIL single_clear got %b want 0000", bus.resp_valid); end
  endtask

  task automatic test_all_four();
    logic [31:0] xs [4];
    logic [31:0] ys [4];
    xs = '{32'h3F80_0000, 32'h4110_0000, 32'h4180_0000, 32'h4000_0000};
    ys = '{32'h3F80_0000, 32'h4040_0000, 32'h4080_0000, 32'h3FB5_04F3};
    apply_reset();
    for (int k = 0; k < 4; k++) bus.req_x[k] = xs[k];
    bus.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 7; cyc++) begin
      #1;
      if (cyc < 4) begin
        n_chk++; if (bus.req_ready !== 4'(1 << cyc)) begin n_fail++; $display("FAIL all4_grant c%0d got %b want %b", cyc, bus.req_ready, 4'(1 << cyc)); end
      end
      if (cyc >= 3) begin
        n_chk++; if (bus.resp_valid !== 4'(1 << (cyc-3))) begin n_fail++; $display("FAIL all4_valid c%0d got %b want %b", cyc, bus.resp_valid, 4'(1 << (cyc-3))); end
        if (cyc == 6) begin
          n_chk++; if (bus.resp_y[3] < 32'h3FB5_04F2 || bus.resp_y[3] > 32'h3FB5_04F4) begin n_fail++; $display("FAIL all4_y3 got %h want 3fb504f3+-1", bus.resp_y[3]); end
        end else begin
          n_chk++; if (bus.resp_y[cyc-3] !== ys[cyc-3]) begin n_fail++; $display("FAIL all4_y%0d got %h want %h", cyc-3, bus.resp_y[cyc-3], ys[cyc-3]); end
        end
      end else begin
        n_chk++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("FAIL all4_early c%0d got %b want 0000", cyc, bus.resp_valid); end
      end
      tick();
      if (cyc < 4) bus.req_valid[cyc] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.resp_ready   = 4'b1101;
    bus.req_valid[1] = 1'b1;
    bus.req_x[1]     = 32'h4110_0000;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got %b want 0010", bus.req_ready); end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 4) begin bus.req_valid[0] = 1'b1; bus.req_x[0] = 32'h3F80_0000; end
      if (cyc == 5) bus.req_valid[0] = 1'b0;
      #1;
      n_chk++; if (bus.req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready1 c%0d got %b want 0", cyc, bus.req_ready[1]); end
      if (cyc >= 3) begin
        n_chk++; if (bus.resp_valid[1] !== 1'b1 || bus.resp_y[1] !== 32'h4040_0000) begin n_fail++; $display("FAIL bp_hold c%0d got v=%b y=%h want v=1 y=40400000", cyc, bus.resp_valid[1], bus.resp_y[1]); end
      end
      if (cyc == 4) begin
        n_chk++; if (bus.req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_other got %b want 1", bus.req_ready[0]); end
      end
    end
    tick();
    bus.resp_ready[1] = 1'b1;
    #1;
    n_chk++; if (bus.req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_hs_cycle got %b want 0", bus.req_ready[1]); end
    tick(); #1;
    n_chk++; if (bus.req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL bp_regrant got %b want 1", bus.req_ready[1]); end
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_exceptions();
    logic [31:0] xs [4];
    logic [31:0] ys [4];
    logic        ex [4];
    xs = '{32'hBF80_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h4180_0000};
    ys = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h4080_0000};
    ex = '{1'b1, 1'b1, 1'b1, 1'b0};
    idle_inputs();
    for (int t = 0; t < 4; t++) begin
      bus.req_valid[2] = 1'b1;
      bus.req_x[2]     = xs[t];
      #1;
      n_chk++; if (bus.req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL exc_grant%0d got %b want 1", t, bus.req_ready[2]); end
      tick(); bus.req_valid[2] = 1'b0;
      tick(); tick(); #1;
      n_chk++; if (bus.resp_valid[2] !== 1'b1 || bus.resp_exception[2] !== ex[t]) begin n_fail++; $display("FAIL exc_flag%0d got v=%b e=%b want v=1 e=%b", t, bus.resp_valid[2], bus.resp_exception[2], ex[t]); end
      if (!ex[t]) begin
        n_chk++; if (bus.resp_y[2] !== ys[t]) begin n_fail++; $display("FAIL exc_y%0d got %h want %h", t, bus.resp_y[2], ys[t]); end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy [12];
    exp_rdy = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0100,
                4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000};
    // pointer rotation: winner 1 moves priority to 2, so 3 beats 0
    apply_reset();
    bus.req_valid = 4'b0010;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_first got %b want 0010", bus.req_ready); end
    tick(); bus.req_valid = 4'b1001; #1;
    n_chk++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_wrap got %b want 1000", bus.req_ready); end
    tick(); bus.req_valid = 4'b0001; #1;
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_next got %b want 0001", bus.req_ready); end
    tick(); bus.req_valid = '0;
    for (int k = 0; k < 5; k++) tick();
    apply_reset();
    bus.req_valid = 4'b0101;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      n_chk++; if (bus.req_ready !== exp_rdy[cyc]) begin n_fail++; $display("FAIL fair c%0d got %b want %b", cyc, bus.req_ready, exp_rdy[cyc]); end
      tick();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    bus.resp_ready = '0;
    bus.req_x      = {32'h0, 32'h4180_0000, 32'h4110_0000, 32'h4080_0000};
    bus.req_valid  = 4'b0111;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      n_chk++; if (bus.req_ready !== 4'(1 << cyc)) begin n_fail++; $display("FAIL mid_grant c%0d got %b want %b", cyc, bus.req_ready, 4'(1 << cyc)); end
      tick();
      bus.req_valid[cyc] = 1'b0;
    end
    #1;
    n_chk++; if (bus.resp_valid !== 4'b0001) begin n_fail++; $display("FAIL mid_inflight got %b want 0001", bus.resp_valid); end
    rstn = 1'b0;
    #1;
    n_chk++; if (bus.resp_valid !== 4'b0 || bus.resp_y[0] !== 32'h0) begin n_fail++; $display("FAIL mid_async got v=%b y=%h want v=0000 y=0", bus.resp_valid, bus.resp_y[0]); end
    tick();
    rstn = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      n_chk++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("FAIL mid_stale c%0d got %b want 0000", cyc, bus.resp_valid); end
      tick();
    end
    bus.req_valid = 4'b1010;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_ptr got %b want 0010", bus.req_ready); end
    tick();
    idle_inputs();
    for (int k = 0; k < 5; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_exceptions();
    test_fairness();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
